// File: rtl/data_bus_ram_slave.sv
// Memory-backed slave for the core data bus: req/gnt request phase with
// programmable grant wait states, byte-enabled writes, full-word reads, and
// an in-order rvalid/rdata response delivered a fixed number of cycles after
// each accepted transaction.
module data_bus_ram_slave #(
    parameter int unsigned MEM_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned GNT_WAIT  = 0,
    parameter int unsigned RESP_LAT  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [3:0]  be,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        gnt,
    output logic        rvalid,
    output logic [31:0] rdata
);

    // Word-index width and the width of the grant wait counter; the counter
    // only has to reach GNT_WAIT, because it clears on every accept.
    localparam int unsigned AW = $clog2(MEM_WORDS);
    localparam int unsigned WW = (GNT_WAIT > 0) ? $clog2(GNT_WAIT + 1) : 1;

    // Size of the window in bytes, kept one bit wider than an address so
    // that a window reaching the top of the address space still compares.
    localparam logic [32:0]   MEM_BYTES   = 33'(MEM_WORDS) * 33'd4;
    localparam logic [WW-1:0] WAIT_TARGET = WW'(GNT_WAIT);

    logic [WW-1:0]       wait_cnt;
    logic                accept;
    logic [31:0]         off;
    logic                in_range;
    logic [AW-1:0]       word_idx;
    logic [31:0]         rd_word;
    logic [31:0]         resp_data;

    logic [31:0]         mem [MEM_WORDS];

    logic [RESP_LAT-1:0] pipe_v;
    logic [31:0]         pipe_d [RESP_LAT];

    // Grant is purely combinational so that with GNT_WAIT=0 a request is
    // accepted in the same cycle it is raised; it is masked while in reset
    // so nothing can be accepted on a reset edge.
    assign gnt    = req && (wait_cnt == WAIT_TARGET) && !rst;
    assign accept = req && gnt;

    // Count cycles a request has been held without a grant; any accept or a
    // dropped request starts the next wait from zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (!req || accept) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + WW'(1);
        end
    end

    // Address decode relative to the base, plus the asynchronous read of the
    // addressed word so the value seen at the accept edge is the old contents.
    always_comb begin
        off       = addr - BASE_ADDR;
        in_range  = ({1'b0, off} < MEM_BYTES);
        word_idx  = off[AW+1:2];
        rd_word   = mem[word_idx];
        resp_data = (!we && in_range) ? rd_word : 32'h0;
    end

    // Byte-enabled write of an accepted in-range store; the array is
    // deliberately left out of reset so contents survive a core reset.
    always_ff @(posedge clk) begin
        if (accept && we && in_range) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[word_idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    // Fixed-latency response shift register: every accept enters stage 0 and
    // advances one stage per cycle, so order is preserved and no entry is
    // ever overwritten before it reaches the output.
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_v <= '0;
            for (int i = 0; i < int'(RESP_LAT); i++) begin
                pipe_d[i] <= 32'h0;
            end
        end else begin
            pipe_v[0] <= accept;
            pipe_d[0] <= accept ? resp_data : 32'h0;
            for (int i = 1; i < int'(RESP_LAT); i++) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_d[i] <= pipe_d[i-1];
            end
        end
    end

    assign rvalid = pipe_v[RESP_LAT-1];
    assign rdata  = rvalid ? pipe_d[RESP_LAT-1] : 32'h0;

endmodule

// File: tb/tb_data_bus_ram_slave.sv
// Self-checking bench for data_bus_ram_slave: three instances with different
// grant wait / response latency settings, a table of vectors for the main
// read/write behaviour and hand-written sequences for reset corner cases.
module tb_data_bus_ram_slave;

    typedef struct packed {
        logic [31:0] cyc;
        logic [31:0] data;
    } exp_t;

    typedef struct packed {
        logic        w;
        logic [3:0]  b;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp;
    } vec_t;

    logic        clk;
    logic        rst    [3];
    logic        req    [3];
    logic        we     [3];
    logic [3:0]  be     [3];
    logic [31:0] addr   [3];
    logic [31:0] wdata  [3];
    logic        gnt    [3];
    logic        rvalid [3];
    logic [31:0] rdata  [3];

    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    bit   mon_en = 0;
    exp_t mon_e;
    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    vec_t tbl[20];

    data_bus_ram_slave #(.MEM_WORDS(1024), .BASE_ADDR(32'h0), .GNT_WAIT(0), .RESP_LAT(1)) u0 (
        .clk(clk), .rst(rst[0]), .req(req[0]), .we(we[0]), .be(be[0]), .addr(addr[0]),
        .wdata(wdata[0]), .gnt(gnt[0]), .rvalid(rvalid[0]), .rdata(rdata[0]));

    data_bus_ram_slave #(.MEM_WORDS(1024), .BASE_ADDR(32'h0), .GNT_WAIT(2), .RESP_LAT(3)) u1 (
        .clk(clk), .rst(rst[1]), .req(req[1]), .we(we[1]), .be(be[1]), .addr(addr[1]),
        .wdata(wdata[1]), .gnt(gnt[1]), .rvalid(rvalid[1]), .rdata(rdata[1]));

    data_bus_ram_slave #(.MEM_WORDS(1024), .BASE_ADDR(32'h0), .GNT_WAIT(0), .RESP_LAT(3)) u2 (
        .clk(clk), .rst(rst[2]), .req(req[2]), .we(we[2]), .be(be[2]), .addr(addr[2]),
        .wdata(wdata[2]), .gnt(gnt[2]), .rvalid(rvalid[2]), .rdata(rdata[2]));

    function automatic int gw(input int k);
        return (k == 1) ? 2 : 0;
    endfunction

    function automatic int rl(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle counter; during a cycle it holds that cycle's index
    always @(posedge clk) cyc <= cyc + 1;

    // Hard time limit so the bench always terminates
    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish, got running, expected done");
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic sb_push(input int k, input exp_t e);
        case (k)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    function automatic int sb_size(input int k);
        case (k)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic exp_t sb_front(input int k);
        case (k)
            0:       return q0[0];
            1:       return q1[0];
            default: return q2[0];
        endcase
    endfunction

    task automatic sb_pop(input int k, output exp_t e);
        case (k)
            0:       e = q0.pop_front();
            1:       e = q1.pop_front();
            default: e = q2.pop_front();
        endcase
    endtask

    task automatic sb_flush(input int k);
        case (k)
            0:       q0.delete();
            1:       q1.delete();
            default: q2.delete();
        endcase
    endtask

    // Drive one transaction on instance k (called at posedge+1), wait for the
    // grant within a bounded number of cycles, check the wait length and push
    // the expected response. req is left high for back-to-back use.
    task automatic applyStimulus(input int k, input logic w, input logic [3:0] b,
                                 input logic [31:0] a, input logic [31:0] d,
                                 input logic [31:0] exp, input string name);
        int   waited;
        bit   got;
        exp_t e;
        req[k]   = 1'b1;
        we[k]    = w;
        be[k]    = b;
        addr[k]  = a;
        wdata[k] = d;
        waited   = 0;
        got      = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (gnt[k] === 1'b1) begin
                got    = 1'b1;
                e.cyc  = 32'(cyc + rl(k));
                e.data = exp;
                sb_push(k, e);
            end else begin
                waited++;
            end
            @(posedge clk);
            #1;
        end
        checkOutput($sformatf("%s_gnt_seen[%0d]", name, k), 32'(got), 32'h1);
        checkOutput($sformatf("%s_gnt_wait[%0d]", name, k), 32'(waited), 32'(gw(k)));
    endtask

    task automatic idle(input int k, input int n);
        req[k] = 1'b0;
        we[k]  = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Response monitor: pops the scoreboard on every rvalid and checks its
    // cycle and data, flags unexpected or missing responses, and checks that
    // rdata is zero while idle.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int k = 0; k < 3; k++) begin
                if (rvalid[k] === 1'b1) begin
                    if (sb_size(k) == 0) begin
                        checkOutput($sformatf("rsp_unexpected[%0d]", k), 32'(rvalid[k]), 32'h0);
                    end else begin
                        sb_pop(k, mon_e);
                        checkOutput($sformatf("rsp_cycle[%0d]", k), 32'(cyc), mon_e.cyc);
                        checkOutput($sformatf("rsp_data[%0d]", k), rdata[k], mon_e.data);
                    end
                end else begin
                    checkOutput($sformatf("idle_rdata[%0d]", k), rdata[k], 32'h0);
                    if (sb_size(k) > 0) begin
                        mon_e = sb_front(k);
                        if (mon_e.cyc <= 32'(cyc)) begin
                            sb_pop(k, mon_e);
                            checkOutput($sformatf("rsp_missing[%0d]", k), 32'(rvalid[k]), 32'h1);
                        end
                    end
                end
            end
        end
    end

    // Main stimulus
    initial begin
        tbl[0]  = '{1'b1, 4'hF, 32'h0000_0010, 32'hCAFE_F00D, 32'h0};
        tbl[1]  = '{1'b0, 4'hF, 32'h0000_0010, 32'h0,         32'hCAFE_F00D};
        tbl[2]  = '{1'b1, 4'hF, 32'h0000_0020, 32'h1122_3344, 32'h0};
        tbl[3]  = '{1'b1, 4'h5, 32'h0000_0020, 32'hAABB_CCDD, 32'h0};
        tbl[4]  = '{1'b0, 4'hF, 32'h0000_0020, 32'h0,         32'h11BB_33DD};
        tbl[5]  = '{1'b0, 4'h0, 32'h0000_0020, 32'h0,         32'h11BB_33DD};
        tbl[6]  = '{1'b1, 4'hF, 32'h0000_0000, 32'hDEAD_BEEF, 32'h0};
        tbl[7]  = '{1'b1, 4'hF, 32'h0000_1000, 32'h1234_5678, 32'h0};
        tbl[8]  = '{1'b0, 4'hF, 32'h0000_1000, 32'h0,         32'h0};
        tbl[9]  = '{1'b0, 4'hF, 32'h0000_0000, 32'h0,         32'hDEAD_BEEF};
        tbl[10] = '{1'b1, 4'hF, 32'h0000_1010, 32'hFFFF_FFFF, 32'h0};
        tbl[11] = '{1'b0, 4'hF, 32'h0000_0013, 32'h0,         32'hCAFE_F00D};
        tbl[12] = '{1'b1, 4'hF, 32'h0000_0024, 32'h5566_7788, 32'h0};
        tbl[13] = '{1'b1, 4'h0, 32'h0000_0024, 32'hFFFF_FFFF, 32'h0};
        tbl[14] = '{1'b0, 4'hF, 32'h0000_0024, 32'h0,         32'h5566_7788};
        tbl[15] = '{1'b1, 4'hF, 32'h0000_0FFC, 32'h0BAD_F00D, 32'h0};
        tbl[16] = '{1'b0, 4'hF, 32'h0000_0FFC, 32'h0,         32'h0BAD_F00D};
        tbl[17] = '{1'b0, 4'hF, 32'hFFFF_FFFC, 32'h0,         32'h0};
        tbl[18] = '{1'b1, 4'h8, 32'h0000_0FFC, 32'hEE00_0000, 32'h0};
        tbl[19] = '{1'b0, 4'hF, 32'h0000_0FFE, 32'h0,         32'hEEAD_F00D};

        for (int k = 0; k < 3; k++) begin
            rst[k]   = 1'b1;
            req[k]   = 1'b1;
            we[k]    = 1'b0;
            be[k]    = 4'h0;
            addr[k]  = 32'h0;
            wdata[k] = 32'h0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checkOutput($sformatf("reset_gnt[%0d]", k), 32'(gnt[k]), 32'h0);
            checkOutput($sformatf("reset_rvalid[%0d]", k), 32'(rvalid[k]), 32'h0);
            checkOutput($sformatf("reset_rdata[%0d]", k), rdata[k], 32'h0);
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            rst[k] = 1'b0;
            req[k] = 1'b0;
        end
        mon_en = 1'b1;

        $display("[TB] instance 0: table vectors, back to back");
        for (int i = 0; i < 20; i++) begin
            applyStimulus(0, tbl[i].w, tbl[i].b, tbl[i].a, tbl[i].d, tbl[i].exp,
                          $sformatf("vec%0d", i));
        end
        idle(0, 4);

        $display("[TB] instance 1: grant wait states and latency 3");
        applyStimulus(1, 1'b1, 4'hF, 32'h40, 32'hA5A5_A5A5, 32'h0, "w40");
        applyStimulus(1, 1'b0, 4'hF, 32'h40, 32'h0, 32'hA5A5_A5A5, "r40");
        idle(1, 6);

        // Request pending across reset must restart its wait count
        req[1]  = 1'b1;
        we[1]   = 1'b0;
        be[1]   = 4'hF;
        addr[1] = 32'h40;
        @(negedge clk);
        checkOutput("pre_rst_gnt[1]", 32'(gnt[1]), 32'h0);
        @(posedge clk);
        #1;
        rst[1] = 1'b1;
        @(negedge clk);
        checkOutput("rst_gnt[1]", 32'(gnt[1]), 32'h0);
        @(posedge clk);
        #1;
        rst[1] = 1'b0;
        applyStimulus(1, 1'b0, 4'hF, 32'h40, 32'h0, 32'hA5A5_A5A5, "r40_after_rst");
        idle(1, 6);

        $display("[TB] instance 2: pipelined reads and reset with reads outstanding");
        applyStimulus(2, 1'b1, 4'hF, 32'h0, 32'h1, 32'h0, "w0");
        applyStimulus(2, 1'b1, 4'hF, 32'h4, 32'h2, 32'h0, "w4");
        applyStimulus(2, 1'b1, 4'hF, 32'h8, 32'h3, 32'h0, "w8");
        applyStimulus(2, 1'b0, 4'hF, 32'h0, 32'h0, 32'h1, "r0");
        applyStimulus(2, 1'b0, 4'hF, 32'h4, 32'h0, 32'h2, "r4");
        applyStimulus(2, 1'b0, 4'hF, 32'h8, 32'h0, 32'h3, "r8");
        idle(2, 6);

        applyStimulus(2, 1'b0, 4'hF, 32'h0, 32'h0, 32'h1, "r0_pre_rst");
        applyStimulus(2, 1'b0, 4'hF, 32'h4, 32'h0, 32'h2, "r4_pre_rst");
        rst[2]  = 1'b1;
        req[2]  = 1'b1;
        addr[2] = 32'h8;
        sb_flush(2);
        @(negedge clk);
        checkOutput("rst_gnt[2]", 32'(gnt[2]), 32'h0);
        @(posedge clk);
        #1;
        req[2] = 1'b0;
        @(posedge clk);
        #1;
        rst[2] = 1'b0;
        idle(2, 6);
        applyStimulus(2, 1'b0, 4'hF, 32'h4, 32'h0, 32'h2, "r4_post_rst");
        applyStimulus(2, 1'b0, 4'hF, 32'h8, 32'h0, 32'h3, "r8_post_rst");
        idle(2, 6);

        for (int k = 0; k < 3; k++) begin
            checkOutput($sformatf("sb_empty[%0d]", k), 32'(sb_size(k)), 32'h0);
        end

        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
